// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared constants and helpers for the 4x4 hex keypad scanner:
//            matrix geometry, key-code width, the row*4+col -> hex code table,
//            and one-hot helpers used to qualify single-key presses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
  localparam int KEYS   = ROWS * COLS;

  // Indexed by row*4+col. Element 0 is the rightmost entry.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
  localparam logic [KEYS-1:0][CODE_W-1:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic is_onehot(input logic [KEYS-1:0] v);
    return (v != '0) && ((v & (v - KEYS'(1))) == '0);
  endfunction

  // Position of the lowest set bit; only meaningful when v is one-hot.
  function automatic logic [3:0] onehot_index(input logic [KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for asynchronous level inputs.
// Ports    : i_clk    - clock
//            i_resetn - asynchronous active-low reset (flops load RESET_VAL)
//            d        - asynchronous input bus
//            q        - synchronized output bus
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix hex keypad scanner. Drives one row low at a time,
//            samples synchronized active-low columns, debounces whole-matrix
//            snapshots and emits one hex code per clean single-key press.
// Ports    : i_clk       - clock (5 MHz)
//            i_resetn    - asynchronous active-low reset
//            rows        - row drive, active-low, exactly one bit low
//            cols        - column sense, active-low, asynchronous
//            key_code    - hex code of the accepted key
//            key_valid   - key_code holds an unconsumed key
//            key_ready   - consumer accepts on key_valid && key_ready
//            key_pressed - debounced matrix non-empty
//            overrun     - sticky: key event dropped while key_valid pending
//            overrun_clr - synchronous clear of overrun (a set wins)
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 4000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  output logic [ROWS-1:0]   rows,
  input  logic [COLS-1:0]   cols,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_pressed,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int ROW_W  = $clog2(ROWS);

  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [ROW_W-1:0]  C_ROW_LAST  = ROW_W'(ROWS - 1);

  logic [COLS-1:0]   w_cols_sync;

  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row;
  logic [ROWS-1:0]   r_rows;
  logic [KEYS-1:0]   r_snap;
  logic [KEYS-1:0]   r_prev_snap;
  logic [CNT_W-1:0]  r_stable_cnt;
  logic [KEYS-1:0]   r_deb;
  logic              r_evt;
  logic [CODE_W-1:0] r_evt_code;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_key_pressed;
  logic              r_overrun;

  logic              w_sample;
  logic              w_scan_end;
  logic [ROW_W-1:0]  w_row_next;
  logic [KEYS-1:0]   w_snap;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_deb_load;
  logic              w_event;
  logic              w_consume;

  sync_2ff #(
    .WIDTH     (COLS),
    .RESET_VAL ({COLS{1'b1}})
  ) u_cols_sync (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .d        (cols),
    .q        (w_cols_sync)
  );

  // Snapshot with the current row's bits merged in; at the row-3 sample this
  // is the complete scan used for the debounce comparison.
  always_comb begin
    w_sample   = (r_tick == C_TICK_LAST);
    w_scan_end = w_sample && (r_row == C_ROW_LAST);
    w_row_next = r_row + ROW_W'(1);
    w_snap     = r_snap;
    w_snap[{r_row, 2'b00} +: COLS] = ~w_cols_sync;
    if (w_snap != r_prev_snap) begin
      w_cnt_next = '0;
    end else if (r_stable_cnt == C_CNT_MAX) begin
      w_cnt_next = r_stable_cnt;
    end else begin
      w_cnt_next = r_stable_cnt + CNT_W'(1);
    end
    w_deb_load = w_scan_end && (w_cnt_next == C_CNT_MAX);
    // Only a transition from an empty matrix to a single key is an event;
    // this blocks auto-repeat and multi-key chords.
    w_event    = w_deb_load && (r_deb == '0) && is_onehot(w_snap);
    w_consume  = r_key_valid && key_ready;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_tick       <= '0;
      r_row        <= '0;
      r_rows       <= 4'b1110;
      r_snap       <= '0;
      r_prev_snap  <= '0;
      r_stable_cnt <= '0;
      r_deb        <= '0;
      r_evt        <= 1'b0;
      r_evt_code   <= '0;
    end else begin
      r_evt <= w_event;
      if (w_event) begin
        r_evt_code <= KEY_MAP[onehot_index(w_snap)];
      end
      if (w_sample) begin
        r_tick <= '0;
        r_row  <= w_row_next;
        r_rows <= ~(ROWS'(1) << w_row_next);
        r_snap <= w_snap;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
      if (w_scan_end) begin
        r_prev_snap  <= w_snap;
        r_stable_cnt <= w_cnt_next;
        if (w_deb_load) begin
          r_deb <= w_snap;
        end
      end
    end
  end

  // Output handshake, one cycle behind the debounced update.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_pressed <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_key_pressed <= (r_deb != '0);
      if (r_evt && (!r_key_valid || w_consume)) begin
        r_key_code  <= r_evt_code;
        r_key_valid <= 1'b1;
      end else if (w_consume) begin
        r_key_valid <= 1'b0;
      end
      if (r_evt && r_key_valid && !key_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rows        = r_rows;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_pressed = r_key_pressed;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire
